ddr3_rx_bitslip_align: RTL
==========================

Name: ddr3_rx_bitslip_align

Overview:
- Receive-side training/alignment block for a DDR3 PHY lane; the read-direction counterpart of the 4:1 output serializer path.
- Takes the 4-bit deserialized word from an RX-mode IOD and issues RX_BIT_SLIP pulses until the word matches a fixed training pattern.
- Once locked, forwards aligned data to the fabric.
- Sits between the lane IOD RX_DATA/RX_BIT_SLIP pins and the DDR read datapath.

Parameters:
- LANE_WIDTH, 4, deserialization ratio and width of the RX word.
- TRAIN_PATTERN, 4'b0011, training word; all 4 rotations are distinct.
- SLIP_WAIT, 8, settle cycles after each slip before comparing (range 1..255).
- MATCH_COUNT, 16, consecutive matches required for lock (range 1..255).
- MAX_SLIPS, 8, slips allowed before declaring error (2×LANE_WIDTH).

Ports:
- FAB_CLK  in  1  fabric clock, same domain as IOD RX_DATA.
- ARST  in  1  asynchronous active-high reset.
- TRAIN_START  in  1  single-cycle pulse; starts or restarts training.
- RX_DATA_IN  in  LANE_WIDTH  deserialized word from IOD.
- RX_BIT_SLIP  out  1  single-cycle slip request to IOD.
- RX_DATA_OUT  out  LANE_WIDTH  registered RX_DATA_IN.
- RX_DATA_VALID  out  1  high while locked, aligned with RX_DATA_OUT.
- BUSY  out  1  training in progress.
- LOCKED  out  1  alignment achieved.
- TRAIN_ERR  out  1  alignment failed.
- SLIP_CNT  out  4  slips issued in the current training run.

Behaviour:
- Clock and reset: one clock, FAB_CLK. Reset ARST is asynchronous and active-high. All flops clear on ARST.
- Reset values: all outputs 0. FSM starts in IDLE.
- States: IDLE, WAIT, CHECK, SLIP, LOCK, ERR.
- IDLE: on TRAIN_START, clear slip_cnt, wait_cnt and match_cnt, then go to WAIT.
- WAIT: wait_cnt increments each cycle. When wait_cnt == SLIP_WAIT-1, clear it and go to CHECK.
- CHECK:
  - RX_DATA_IN == TRAIN_PATTERN: match_cnt++. When match_cnt reaches MATCH_COUNT (the MATCH_COUNT-th consecutive match), go to LOCK.
  - Mismatch: clear match_cnt. If slip_cnt == MAX_SLIPS, go to ERR; otherwise go to SLIP.
- SLIP: lasts exactly one cycle. RX_BIT_SLIP=1 (registered output, high in the cycle after the CHECK mismatch). slip_cnt++. Go to WAIT.
- LOCK: LOCKED=1. No further compares.
- ERR: TRAIN_ERR=1.
- TRAIN_START handling:
  - In any state, TRAIN_START restarts training: counters cleared, LOCKED and TRAIN_ERR deassert next cycle, state goes to WAIT.
  - TRAIN_START in SLIP: the slip pulse already in progress completes; nothing is cancelled mid-pulse.
- BUSY = 1 in WAIT, CHECK and SLIP.
- SLIP_CNT mirrors slip_cnt. Saturates at 15; never wraps.
- Data path:
  - RX_DATA_OUT: 1-cycle latency, always registered regardless of state.
  - RX_DATA_VALID = registered (state==LOCK), so it is cycle-aligned with RX_DATA_OUT.
- Minimum lock latency with zero slips: SLIP_WAIT + MATCH_COUNT cycles after TRAIN_START.
- Each slip adds 1 + SLIP_WAIT cycles plus the mismatch cycle.
- ARST mid-training: immediate return to IDLE. RX_BIT_SLIP forced low.

Optional Feature:
- Macro: DDR3_RX_ALIGN_STATS_EN.
- Defined: adds output MISMATCH_CNT [15:0].
  - Counts CHECK-state mismatch cycles.
  - Saturates at 16'hFFFF.
  - Cleared on ARST and on TRAIN_START.
- Undefined: port and counter absent. All other behaviour identical.

Decomposition:
- Package ddr3_rx_align_pkg holds:
  - State enum type (IDLE/WAIT/CHECK/SLIP/LOCK/ERR).
  - Default TRAIN_PATTERN constant.
  - Counter width constants: 8-bit wait/match, 4-bit slip.
- Single module; no sub-module is needed. The FSM and counters are tightly coupled.

Test Plan:
1. Aligned input: RX_DATA_IN held at 4'b0011, TRAIN_START pulse → no RX_BIT_SLIP; LOCKED rises 24 cycles after start; SLIP_CNT=0; RX_DATA_VALID one cycle later.
2. Rotated input: bench model rotates the word by one on each slip, starting at 4'b0110 → exactly 3 slip pulses, each 1 cycle wide and ≥9 cycles apart; LOCKED=1; SLIP_CNT=3.
3. Never-matching input: RX_DATA_IN held at 4'b1111 → 8 slips, then TRAIN_ERR=1, LOCKED=0, BUSY=0, SLIP_CNT=8.
4. Mismatch at match 10 of 16 → match_cnt clears, one slip issued; lock requires 16 fresh consecutive matches.
5. ARST asserted during SLIP state → RX_BIT_SLIP low in the same cycle (asynchronous); all outputs 0; TRAIN_START afterwards relocks normally.
6. DDR3_RX_ALIGN_STATS_EN defined, scenario 3 → MISMATCH_CNT=9. A new TRAIN_START clears it to 0.

Source files
------------

// File: rtl/ddr3_rx_align_pkg.sv
// Shared types and constants for the DDR3 RX bitslip alignment block.
package ddr3_rx_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_SLIP,
    ST_LOCK,
    ST_ERR
  } align_state_t;

  localparam logic [3:0] DEFAULT_TRAIN_PATTERN = 4'b0011;

  localparam int WAIT_CNT_W  = 8;
  localparam int MATCH_CNT_W = 8;
  localparam int SLIP_CNT_W  = 4;

endpackage

// File: rtl/ddr3_rx_bitslip_align.sv
// DDR3 PHY lane RX word aligner: slips the IOD deserializer until the training
// pattern is seen MATCH_COUNT times in a row. Optional macro DDR3_RX_ALIGN_STATS_EN adds MISMATCH_CNT.
module ddr3_rx_bitslip_align
  import ddr3_rx_align_pkg::*;
#(
  parameter int                    LANE_WIDTH    = 4,
  parameter logic [LANE_WIDTH-1:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int                    SLIP_WAIT     = 8,
  parameter int                    MATCH_COUNT   = 16,
  parameter int                    MAX_SLIPS     = 8
) (
  input  logic                  FAB_CLK,
  input  logic                  ARST,
  input  logic                  TRAIN_START,
  input  logic [LANE_WIDTH-1:0] RX_DATA_IN,
  output logic                  RX_BIT_SLIP,
  output logic [LANE_WIDTH-1:0] RX_DATA_OUT,
  output logic                  RX_DATA_VALID,
  output logic                  BUSY,
  output logic                  LOCKED,
  output logic                  TRAIN_ERR,
  output logic [SLIP_CNT_W-1:0] SLIP_CNT
`ifdef DDR3_RX_ALIGN_STATS_EN
  ,
  output logic [15:0]           MISMATCH_CNT
`endif
);

  localparam logic [WAIT_CNT_W-1:0]  WAIT_LAST  = WAIT_CNT_W'(SLIP_WAIT - 1);
  localparam logic [MATCH_CNT_W-1:0] MATCH_LAST = MATCH_CNT_W'(MATCH_COUNT - 1);
  localparam logic [SLIP_CNT_W-1:0]  SLIP_LIMIT = SLIP_CNT_W'(MAX_SLIPS);

  align_state_t           state, state_nxt;
  logic [WAIT_CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [MATCH_CNT_W-1:0] match_cnt, match_cnt_nxt;
  logic [SLIP_CNT_W-1:0]  slip_cnt, slip_cnt_nxt;

  // TRAIN_START overrides every state; a slip pulse already on the pins is
  // not affected because RX_BIT_SLIP is its own flop.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    match_cnt_nxt = match_cnt;
    slip_cnt_nxt  = slip_cnt;
    if (TRAIN_START) begin
      state_nxt     = ST_WAIT;
      wait_cnt_nxt  = '0;
      match_cnt_nxt = '0;
      slip_cnt_nxt  = '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt_nxt = '0;
            state_nxt    = ST_CHECK;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (RX_DATA_IN == TRAIN_PATTERN) begin
            match_cnt_nxt = match_cnt + 1'b1;
            if (match_cnt == MATCH_LAST) state_nxt = ST_LOCK;
          end else begin
            match_cnt_nxt = '0;
            state_nxt     = (slip_cnt == SLIP_LIMIT) ? ST_ERR : ST_SLIP;
          end
        end
        ST_SLIP: begin
          if (slip_cnt != '1) slip_cnt_nxt = slip_cnt + 1'b1;
          state_nxt = ST_WAIT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      match_cnt     <= '0;
      slip_cnt      <= '0;
      RX_BIT_SLIP   <= 1'b0;
      RX_DATA_OUT   <= '0;
      RX_DATA_VALID <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_cnt_nxt;
      match_cnt     <= match_cnt_nxt;
      slip_cnt      <= slip_cnt_nxt;
      RX_BIT_SLIP   <= (state_nxt == ST_SLIP);
      RX_DATA_OUT   <= RX_DATA_IN;
      RX_DATA_VALID <= (state == ST_LOCK);
    end
  end

  assign BUSY      = (state == ST_WAIT) || (state == ST_CHECK) || (state == ST_SLIP);
  assign LOCKED    = (state == ST_LOCK);
  assign TRAIN_ERR = (state == ST_ERR);
  assign SLIP_CNT  = slip_cnt;

`ifdef DDR3_RX_ALIGN_STATS_EN
  logic [15:0] mismatch_cnt;
  logic        mismatch_hit;

  assign mismatch_hit = (state == ST_CHECK) && (RX_DATA_IN != TRAIN_PATTERN);

  // Saturating count of CHECK-state mismatches, restarted with each training run.
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      mismatch_cnt <= '0;
    end else if (TRAIN_START) begin
      mismatch_cnt <= '0;
    end else if (mismatch_hit && (mismatch_cnt != 16'hFFFF)) begin
      mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end

  assign MISMATCH_CNT = mismatch_cnt;
`endif

endmodule
